// File: rtl/ps2_key_queue.sv
// ps2_key_queue
//   Buffers PS/2 keyboard events arriving on the toggle-based ps2_key bus
//   into a small FIFO that the CPU drains one entry per pop strobe.
//   Show-ahead: dout always presents the head entry (0 when empty).
//
// Ports
//   clk_24    in   system clock, rising edge
//   reset     in   synchronous, active-high
//   ps2_key   in   [10] event toggle, [9] pressed, [8] extended, [7:0] code
//   pop       in   one-cycle strobe, removes the head entry
//   ovf_clr   in   one-cycle strobe, clears the sticky overflow flag
//   dout      out  head entry {pressed, extended, code}, 0 when empty
//   empty     out  queue holds no entries
//   full      out  count == DEPTH
//   count     out  number of stored entries, 0..DEPTH
//   overflow  out  sticky, set when an event is dropped
//
// Handshake: a push is any change of ps2_key[10] versus the value seen on the
// previous edge; it is accepted unless the queue is full with no pop on the
// same edge. A pop is accepted only when the queue is not empty. Both can be
// accepted on the same edge.
module ps2_key_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_24,
  input  logic              reset,
  input  logic [10:0]       ps2_key,
  input  logic              pop,
  input  logic              ovf_clr,
  output logic [9:0]        dout,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] L_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] L_ONE  = (ADDR_W+1)'(1);

  logic              r_tog;
  logic [9:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wp;
  logic [ADDR_W-1:0] r_rp;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;

  logic w_push;
  logic w_empty;
  logic w_full;
  logic w_push_acc;
  logic w_pop_acc;
  logic w_drop;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == L_FULL);
  // Gated by reset so a toggle seen during reset is absorbed, never queued.
  assign w_push     = (ps2_key[10] != r_tog) && !reset;
  // When full, a same-edge pop frees the slot the push needs.
  assign w_push_acc = w_push && (!w_full || pop);
  assign w_pop_acc  = pop && !w_empty;
  assign w_drop     = w_push && w_full && !pop;

  // Toggle history follows the bus every cycle, reset included, so releasing
  // reset never looks like a new event.
  always_ff @(posedge clk_24) begin
    r_tog <= ps2_key[10];
  end

  // Storage is not reset; entries are only visible through r_count.
  always_ff @(posedge clk_24) begin
    if (w_push_acc) begin
      r_mem[r_wp] <= ps2_key[9:0];
    end
  end

  always_ff @(posedge clk_24) begin
    if (reset) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_acc) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop_acc) begin
        r_rp <= r_rp + 1'b1;
      end
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + L_ONE;
        2'b01:   r_count <= r_count - L_ONE;
        default: r_count <= r_count;
      endcase
      // A drop on the same edge as a clear wins.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign dout     = w_empty ? 10'h000 : r_mem[r_rp];
  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_ps2_key_queue.sv
module tb_ps2_key_queue;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk_24;
  logic              reset;
  logic [10:0]       ps2_key;
  logic              pop;
  logic              ovf_clr;
  logic [9:0]        dout;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;

  int checks   = 0;
  int failures = 0;

  // Reference model: the queue contents and the sticky flag.
  logic [9:0] exp_q[$];
  bit         m_ovf;

  ps2_key_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_24   (clk_24),
    .reset    (reset),
    .ps2_key  (ps2_key),
    .pop      (pop),
    .ovf_clr  (ovf_clr),
    .dout     (dout),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  // Clock / reset block
  initial clk_24 = 1'b0;
  always #5 clk_24 = ~clk_24;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".count"},    32'(count),    32'(exp_q.size()));
    chk({tag, ".empty"},    32'(empty),    32'(exp_q.size() == 0));
    chk({tag, ".full"},     32'(full),     32'(exp_q.size() == DEPTH));
    chk({tag, ".dout"},     32'(dout),     (exp_q.size() == 0) ? 32'h0 : 32'(exp_q[0]));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  // Driver: one clock cycle with optional event, pop, clear and reset.
  task automatic cycle(input bit push, input logic [9:0] d, input bit p,
                       input bit clr, input bit rst, input string tag);
    bit was_full;
    if (push) ps2_key = {~ps2_key[10], d};
    else      ps2_key = {ps2_key[10], 10'($urandom)};
    pop     = p;
    ovf_clr = clr;
    reset   = rst;
    // Model update from the behavioural rules
    if (rst) begin
      exp_q.delete();
      m_ovf = 1'b0;
    end else begin
      was_full = (exp_q.size() == DEPTH);
      if (push && was_full && !p) begin
        m_ovf = 1'b1;
      end else begin
        if (p && exp_q.size() > 0) void'(exp_q.pop_front());
        if (push) exp_q.push_back(d);
        if (clr) m_ovf = 1'b0;
      end
    end
    @(posedge clk_24);
    #1;
    pop     = 1'b0;
    ovf_clr = 1'b0;
    reset   = 1'b0;
    chk_model(tag);
  endtask

  initial begin
    int pushed;
    logic [9:0] d;
    reset   = 1'b1;
    pop     = 1'b0;
    ovf_clr = 1'b0;
    ps2_key = 11'h41C;

    // Reset with toggle bit high held through reset
    for (int i = 0; i < 3; i++) cycle(1'b0, 10'h0, 1'b0, 1'b0, 1'b1, "reset");
    ps2_key = 11'h41C;
    chk("reset.dout_const", 32'(dout), 32'h0);
    for (int i = 0; i < 10; i++) begin
      pop = 1'b0; ovf_clr = 1'b0; reset = 1'b0;
      @(posedge clk_24); #1;
      chk("release.empty", 32'(empty), 32'h1);
      chk("release.count", 32'(count), 32'h0);
    end

    // First event and its latency
    cycle(1'b1, 10'h21C, 1'b0, 1'b0, 1'b0, "first");
    chk("first.dout_const", 32'(dout), 32'h21C);
    chk("first.count_const", 32'(count), 32'h1);
    cycle(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, "first_pop");

    // Three events on consecutive cycles, then drain
    cycle(1'b1, 10'h21C, 1'b0, 1'b0, 1'b0, "three");
    cycle(1'b1, 10'h31C, 1'b0, 1'b0, 1'b0, "three");
    cycle(1'b1, 10'h01C, 1'b0, 1'b0, 1'b0, "three");
    chk("three.count_const", 32'(count), 32'h3);
    chk("three.head_const", 32'(dout), 32'h21C);
    cycle(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, "drain3");
    chk("drain3.second", 32'(dout), 32'h31C);
    cycle(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, "drain3");
    chk("drain3.third", 32'(dout), 32'h01C);
    cycle(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, "drain3");
    chk("drain3.empty_dout", 32'(dout), 32'h0);
    cycle(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, "pop_empty");
    chk("pop_empty.overflow", 32'(overflow), 32'h0);

    // Overflow: 17 events, no pops
    for (int i = 0; i <= 16; i++) cycle(1'b1, 10'(i), 1'b0, 1'b0, 1'b0, "ovf_fill");
    chk("ovf.full_const", 32'(full), 32'h1);
    chk("ovf.flag_const", 32'(overflow), 32'h1);
    for (int i = 0; i < 16; i++) begin
      chk("ovf.drain_code", 32'(dout), 32'(i));
      cycle(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, "ovf_drain");
    end

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) cycle(1'b1, 10'(i + 32), 1'b0, 1'b0, 1'b0, "refill");
    cycle(1'b0, 10'h0, 1'b0, 1'b1, 1'b0, "clr");
    cycle(1'b1, 10'h0AA, 1'b1, 1'b0, 1'b0, "full_pp");
    chk("full_pp.count_const", 32'(count), 32'd16);
    chk("full_pp.ovf_const", 32'(overflow), 32'h0);
    for (int i = 0; i < 15; i++) cycle(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, "full_pp_drain");
    chk("full_pp.last_aa", 32'(dout), 32'h0AA);
    cycle(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, "full_pp_drain");

    // Drop on the same edge as ovf_clr
    for (int i = 0; i < 16; i++) cycle(1'b1, 10'($urandom), 1'b0, 1'b0, 1'b0, "refill2");
    cycle(1'b1, 10'h155, 1'b0, 1'b1, 1'b0, "drop_clr");
    chk("drop_clr.ovf_const", 32'(overflow), 32'h1);
    cycle(1'b0, 10'h0, 1'b0, 1'b1, 1'b0, "clr_alone");
    chk("clr_alone.ovf_const", 32'(overflow), 32'h0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, "drain2");

    // Wrap-around: 3 pushes then 2 pops until 40 events, then drain
    pushed = 0;
    while (pushed < 40) begin
      for (int k = 0; k < 3 && pushed < 40; k++) begin
        d = 10'($urandom);
        cycle(1'b1, d, 1'b0, 1'b0, 1'b0, "wrap_push");
        pushed++;
      end
      for (int k = 0; k < 2; k++) cycle(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, "wrap_pop");
    end
    while (exp_q.size() > 0) cycle(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, "wrap_drain");

    // Randomized mix of push, pop and clear
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 10'($urandom), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 15) == 0), 1'b0, "rand");
    end

    // Reset mid-operation while toggling
    while (exp_q.size() > 0) cycle(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, "pre_rst_drain");
    for (int i = 0; i < 5; i++) cycle(1'b1, 10'($urandom), 1'b0, 1'b0, 1'b0, "pre_rst");
    chk("pre_rst.count_const", 32'(count), 32'd5);
    cycle(1'b1, 10'h2F0, 1'b0, 1'b0, 1'b1, "mid_rst");
    chk("mid_rst.count_const", 32'(count), 32'h0);
    chk("mid_rst.empty_const", 32'(empty), 32'h1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 10'h0, 1'b0, 1'b0, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
